// File: rtl/camera_pkg.sv
// camera_pkg
// Shared definitions for the camera exposure/readout sequencer:
//   - exposure time limits and reset value (ms)
//   - fixed readout slot length of the timer (counts)
//   - sequencer state encoding and the per-state control word decode

package camera_pkg;

  localparam int EXP_MIN   = 2;
  localparam int EXP_MAX   = 30;
  localparam int EXP_RST   = 2;
  localparam int READ_SLOT = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ERASE  = 3'd1,
    ST_EXPOSE = 3'd2,
    ST_GAP1   = 3'd3,
    ST_READ1  = 3'd4,
    ST_CONV1  = 3'd5,
    ST_READ2  = 3'd6,
    ST_CONV2  = 3'd7
  } state_t;

  // Control word driven to the timer and pixel array.
  // nre_1/nre_2 are active-low, so their inactive value is 1.
  typedef struct packed {
    logic start;
    logic erase;
    logic expose;
    logic nre_1;
    logic nre_2;
    logic adc;
    logic busy;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{start: 1'b0, erase: 1'b0, expose: 1'b0,
                                  nre_1: 1'b1, nre_2: 1'b1, adc: 1'b0,
                                  busy: 1'b0};

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c      = CTRL_IDLE;
    c.busy = (s != ST_IDLE);
    case (s)
      ST_ERASE:  c.erase  = 1'b1;
      ST_EXPOSE: begin
        c.expose = 1'b1;
        c.start  = 1'b1;
      end
      ST_READ1:  begin
        c.nre_1 = 1'b0;
        c.start = 1'b1;
      end
      ST_CONV1:  begin
        c.nre_1 = 1'b0;
        c.adc   = 1'b1;
      end
      ST_READ2:  begin
        c.nre_2 = 1'b0;
        c.start = 1'b1;
      end
      ST_CONV2:  begin
        c.nre_2 = 1'b0;
        c.adc   = 1'b1;
      end
      default:   c = c;  // IDLE and GAP1 keep the inactive values
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exp_time_adjust.sv
// exp_time_adjust
// Rising-edge detection on the two exposure buttons and the saturating
// up/down exposure time register.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   enable   in   adjustments accepted only while high (sequencer idle)
//   increase in   button level; rising edge adds 1 (saturates at EXP_MAX)
//   decrease in   button level; rising edge subtracts 1 (saturates at EXP_MIN)
//   exp_time out  current exposure time

module exp_time_adjust
  import camera_pkg::*;
#(
  parameter int EXP_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             increase,
  input  logic             decrease,
  output logic [EXP_W-1:0] exp_time
);

  localparam logic [EXP_W-1:0] MIN_V = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] MAX_V = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] RST_V = EXP_W'(EXP_RST);
  localparam logic [EXP_W-1:0] ONE_V = EXP_W'(1);

  logic inc_q;
  logic dec_q;
  logic inc_edge;
  logic dec_edge;

  assign inc_edge = increase & ~inc_q;
  assign dec_edge = decrease & ~dec_q;

  // Edges arriving while disabled are consumed by the history flops and
  // therefore discarded rather than queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      exp_time <= RST_V;
    end else begin
      inc_q <= increase;
      dec_q <= decrease;
      if (enable && inc_edge && !dec_edge && (exp_time != MAX_V)) begin
        exp_time <= exp_time + ONE_V;
      end else if (enable && dec_edge && !inc_edge && (exp_time != MIN_V)) begin
        exp_time <= exp_time - ONE_V;
      end
    end
  end

endmodule

// File: rtl/exposure_controller.sv
// exposure_controller
// Sequences one capture: erase, expose (timed by Ovf5), then two row
// readouts (each timed by Ovf4) followed by an ADC strobe.
// Ports:
//   Clk           in   system clock
//   Reset         in   asynchronous active-low reset
//   Init          in   capture request level (rising edge starts a capture)
//   Exp_increase  in   exposure +1 button level
//   Exp_decrease  in   exposure -1 button level
//   Ovf5          in   timer: exposure interval elapsed
//   Ovf4          in   timer: readout slot elapsed
//   Start         out  timer enable (0 clears the timer)
//   Exp_Time      out  current exposure time to the timer
//   Erase         out  pixel erase strobe
//   Expose        out  pixel integrate enable
//   NRE_1, NRE_2  out  active-low row-read enables
//   ADC           out  ADC convert strobe
//   Busy          out  high whenever not idle
//   state_dbg     out  current sequencer state

module exposure_controller
  import camera_pkg::*;
#(
  parameter int EXP_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  input  logic             Ovf5,
  input  logic             Ovf4,
  output logic             Start,
  output logic [EXP_W-1:0] Exp_Time,
  output logic             Erase,
  output logic             Expose,
  output logic             NRE_1,
  output logic             NRE_2,
  output logic             ADC,
  output logic             Busy,
  output state_t           state_dbg
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  logic   init_q;
  logic   init_edge;
  logic   adj_en;

  assign init_edge = Init & ~init_q;
  // A capture request wins over adjust edges arriving in the same cycle.
  assign adj_en    = (state == ST_IDLE) && !init_edge;

  exp_time_adjust #(
    .EXP_W (EXP_W)
  ) u_exp_time_adjust (
    .clk      (Clk),
    .rst_n    (Reset),
    .enable   (adj_en),
    .increase (Exp_increase),
    .decrease (Exp_decrease),
    .exp_time (Exp_Time)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (init_edge) state_nxt = ST_ERASE;
      ST_ERASE:  state_nxt = ST_EXPOSE;
      ST_EXPOSE: if (Ovf5) state_nxt = ST_GAP1;
      ST_GAP1:   state_nxt = ST_READ1;
      ST_READ1:  if (Ovf4) state_nxt = ST_CONV1;
      ST_CONV1:  state_nxt = ST_READ2;
      ST_READ2:  if (Ovf4) state_nxt = ST_CONV2;
      ST_CONV2:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The control word is registered from the next state so every output
  // comes straight off a flop and tracks the state register exactly.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= ST_IDLE;
      init_q <= 1'b0;
      ctrl   <= CTRL_IDLE;
    end else begin
      state  <= state_nxt;
      init_q <= Init;
      ctrl   <= decode_state(state_nxt);
    end
  end

  assign Start     = ctrl.start;
  assign Erase     = ctrl.erase;
  assign Expose    = ctrl.expose;
  assign NRE_1     = ctrl.nre_1;
  assign NRE_2     = ctrl.nre_2;
  assign ADC       = ctrl.adc;
  assign Busy      = ctrl.busy;
  assign state_dbg = state;

endmodule

// File: doc/exposure_controller.md
# exposure_controller

Top-level sequencer for the camera's exposure and readout cycle. Holds the user-adjustable exposure time, and on a capture request runs the pixel array through its erase, expose, row-1 readout and row-2 readout phases. Drives the Timer_Counter through its Start, Exp_Time, Ovf5 and Ovf4 signals. Sits between the button inputs and the pixel array/ADC.

## Interface
- EXP_W, 5: width of Exp_Time.
- EXP_MIN, 2: lowest exposure time (ms).
- EXP_MAX, 30: highest exposure time (ms).
- EXP_RST, 2: exposure time loaded at reset.
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset (Reset=0 clears all state immediately).
- Init  in  1  capture request, level input; its rising edge is detected internally.
- Exp_increase  in  1  rising edge increments Exp_Time.
- Exp_decrease  in  1  rising edge decrements Exp_Time.
- Ovf5  in  1  from timer: exposure interval (Exp_Time) elapsed.
- Ovf4  in  1  from timer: fixed 4-count readout slot elapsed.
- Start  out  1  timer enable; Start=0 clears the timer count.
- Exp_Time  out  EXP_W  current exposure time, to timer.
- Erase  out  1  pixel erase strobe.
- Expose  out  1  pixel integrate enable.
- NRE_1, NRE_2  out  1  active-low row-read enables.
- ADC  out  1  ADC convert strobe.
- Busy  out  1  high in every state except IDLE.

## Operation
- Edge detection: one flop per button (Init, Exp_increase, Exp_decrease). Edge = input & ~previous-sample.
- Exp_Time register:
  - Changes only in IDLE.
  - An increase edge adds 1, saturating at EXP_MAX.
  - A decrease edge subtracts 1, saturating at EXP_MIN.
  - Increase and decrease edges in the same cycle: no change.
  - Edges while Busy=1 are discarded, not queued.
- FSM states and transitions:
  - IDLE: Init edge → ERASE. If adjust edges arrive in the same cycle, Init wins and the adjust edges are dropped.
  - ERASE: unconditional → EXPOSE.
  - EXPOSE: Ovf5=1 → GAP1.
  - GAP1: unconditional → READ1.
  - READ1: Ovf4=1 → CONV1.
  - CONV1: unconditional → READ2.
  - READ2: Ovf4=1 → CONV2.
  - CONV2: unconditional → IDLE.
- Output decode per state (Moore, from state flops only). Each list gives the signals driven active; everything else is inactive.
  - IDLE: none. Start=0, Erase=0, Expose=0, NRE_1=1, NRE_2=1, ADC=0, Busy=0.
  - ERASE: Erase=1, Busy=1. Start=0, so the timer is cleared.
  - EXPOSE: Expose=1, Start=1.
  - GAP1: Start=0, re-arming the timer.
  - READ1: NRE_1=0, Start=1.
  - CONV1: NRE_1=0, ADC=1, Start=0.
  - READ2: NRE_2=0, Start=1.
  - CONV2: NRE_2=0, ADC=1, Start=0.
- Ovf5 is ignored outside EXPOSE. Ovf4 is ignored outside READ1 and READ2.
- Init held high through a whole capture does not retrigger on return to IDLE. A new rising edge is required.

## Timing
- Reset=0 (async), all outputs: state=IDLE, Exp_Time=EXP_RST, edge flops=0, IDLE output values.
- Reset asserted mid-capture: abort immediately to IDLE outputs. No partial readout completes.
- Latency:
  - Init edge sampled at edge k → Erase=1 for exactly the cycle after k.
  - Expose=1 from edge k+1 until the edge where Ovf5 is sampled high.
  - Adjust edge sampled at edge k → new Exp_Time visible after edge k.
- ADC is a 1-cycle strobe. The NRE line of the current row stays low during its ADC cycle.
- NRE_1 and NRE_2 are never low simultaneously.
- Start drops for at least one cycle between consecutive timer intervals. Minimum capture length is 7 cycles plus the timer intervals.
- Glitch-free: every output is a decode of registered state.

## Structure
- Package camera_pkg holds:
  - the state enum (8 states, binary encoded);
  - EXP_MIN, EXP_MAX, EXP_RST;
  - the readout slot constant (4).
- One sub-module: exp_time_adjust. It contains the two edge detectors, the saturating up/down register and the enable input (IDLE). The Init edge detector and the FSM stay in exposure_controller.

## Test plan
- Reset check: Reset=0, then release → Exp_Time=2, NRE_1=NRE_2=1, all other outputs 0. Then 3 increase edges → Exp_Time=5.
- Saturation: 30 increase edges → Exp_Time stops at 30. 40 decrease edges → Exp_Time stops at 2. Simultaneous increase and decrease edges → unchanged.
- Full capture with Exp_Time=8 and a timer model → exact sequence Erase(1 cycle), Expose, Start gap, NRE_1 low, ADC, NRE_2 low, ADC, then IDLE with Busy=0.
- Adjust while busy: increase edge during EXPOSE → Exp_Time unchanged after capture. Init held high throughout → no second capture.
- Stray overflows: Ovf4 pulsed during EXPOSE and Ovf5 pulsed during READ1 → no state change.
- Reset pulsed during READ2 → outputs return to idle values asynchronously, and Exp_Time returns to 2.
